// File: rtl/sata_cmd_split_pkg.sv
// sata_cmd_pkg: shared command layout, FSM states and sector geometry for sata_cmd_split.
package sata_cmd_pkg;
  localparam int DW_PER_SECTOR = 128;
  typedef struct packed {
    logic        rw;
    logic [22:0] len;
    logic [47:0] addr;
  } sata_cmd_t;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DONE, ERR} state_e;
  // Sectors touched by a chunk of dw dwords, rounded up.
  function automatic logic [47:0] sectors(input logic [22:0] dw);
    logic [23:0] s;
    s = {1'b0, dw} + 24'(DW_PER_SECTOR - 1);
    return 48'(s >> $clog2(DW_PER_SECTOR));
  endfunction
endpackage

// File: rtl/sata_cmd_split_timeout.sv
// sata_cmd_timeout: loadable down-counter; expired is high once the count reaches zero.
module sata_cmd_timeout #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/sata_cmd_split.sv
// sata_cmd_split: splits an upstream SATA command into MAX_DW-dword chunks with ack timeout and abort.
// Define SATA_CMD_SPLIT_STAT_EN to enable the chunk_cnt statistics counter.
module sata_cmd_split
  import sata_cmd_pkg::*;
#(
  parameter int MAX_DW      = 8192,
  parameter int ACK_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] s_cmd,
  input  logic        s_cmd_req,
  output logic        s_cmd_ack,
  output logic [71:0] m_cmd,
  output logic        m_cmd_req,
  input  logic        m_cmd_ack,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] chunk_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_e      state_q, state_d;
  sata_cmd_t   cmd_q, cmd_d, in_cmd;
  logic [22:0] chunk;
  logic        acc, ack, expired;
  assign in_cmd = s_cmd;
  assign chunk  = cmd_q.len > 23'(MAX_DW) ? 23'(MAX_DW) : cmd_q.len;
  assign acc    = state_q == IDLE && s_cmd_req;
  assign ack    = state_q == ISSUE && m_cmd_ack;
  sata_cmd_timeout #(.W(TW)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q != ISSUE),
    .load_val (TW'(ACK_TIMEOUT - 1)),
    .expired  (expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (s_cmd_req) state_d = in_cmd.len == '0 ? ERR : ISSUE;
      ISSUE: if (m_cmd_ack) state_d = abort ? ERR : (cmd_q.len == chunk ? DONE : GAP);
             else if (abort || expired) state_d = ERR;
      GAP:   state_d = abort ? ERR : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  // Remaining length and sector address advance once per acknowledged chunk.
  always_comb cmd_d = acc ? in_cmd
                    : ack ? {cmd_q.rw, cmd_q.len - chunk, cmd_q.addr + sectors(chunk)}
                    : cmd_q;
  always_comb begin
    s_cmd_ack = acc && rst_n;
    m_cmd_req = state_q == ISSUE;
    m_cmd     = {cmd_q.rw, chunk, cmd_q.addr};
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    err       = state_q == ERR;
  end
`ifdef SATA_CMD_SPLIT_STAT_EN
  logic [31:0] chunk_cnt_q, chunk_cnt_d;
  assign chunk_cnt_d = chunk_cnt_q + 32'(ack);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chunk_cnt_q <= '0;
    else chunk_cnt_q <= chunk_cnt_d;
  assign chunk_cnt = chunk_cnt_q;
`else
  assign chunk_cnt = '0;
`endif
endmodule
